// File: rtl/regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_ctrl
// Description : Debug controller that dumps the decode-stage register bank
//               over a byte-wide transmit handshake. It walks register
//               addresses 0..N_REGS-1 through read port A. For each register
//               it captures the read word and sends it MSB first, one byte per
//               accepted handshake.
//               It only operates while the pipeline is halted. The debug unit
//               raises start_i after the halt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature (macro REGFILE_DUMP_PC_EN):
//   When defined, the controller sends the decode PC (pc_i) as one extra
//   word after the last register, through a PC_LOAD state.
//   When undefined, pc_i is ignored.
// ----------------------------------------------------------------------------
// Ports:
//   clock_i                 in   system clock
//   reset_i                 in   synchronous, active-low reset
//   start_i                 in   dump request, sampled in IDLE only
//   data_ra_i               in   register bank port A read data
//   pc_i                    in   decode PC (optional feature only)
//   tx_ready_i              in   transmitter can accept a byte
//   select_debug_or_wireA_o out  port A address taken from addr_reg_debug_o
//   addr_reg_debug_o        out  register address being read
//   tx_valid_o              out  tx_data_o holds a valid byte
//   tx_data_o               out  byte to transmit
//   busy_o                  out  dump in progress
//   done_o                  out  one-cycle pulse at end of dump
// ============================================================================
module regfile_dump_ctrl #(
    parameter int NB_DATA = 32,   // must be a multiple of NB_BYTE
    parameter int NB_REG  = 5,
    parameter int N_REGS  = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [NB_DATA-1:0] data_ra_i,
    input  logic [NB_DATA-1:0] pc_i,
    input  logic               tx_ready_i,
    output logic               select_debug_or_wireA_o,
    output logic [NB_REG-1:0]  addr_reg_debug_o,
    output logic               tx_valid_o,
    output logic [NB_BYTE-1:0] tx_data_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int c_bytes_per_word = NB_DATA / NB_BYTE;
    localparam int c_nb_cnt         = (c_bytes_per_word > 1) ? $clog2(c_bytes_per_word) : 1;
    localparam logic [c_nb_cnt-1:0] c_last_byte = c_nb_cnt'(c_bytes_per_word - 1);
    localparam logic [NB_REG-1:0]   c_last_addr = NB_REG'(N_REGS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_SEND    = 3'd2,
`ifdef REGFILE_DUMP_PC_EN
        ST_PC_LOAD = 3'd4,
`endif
        ST_DONE    = 3'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [NB_DATA-1:0]  r_word;
    logic [c_nb_cnt-1:0] r_byte_cnt;
    logic [NB_REG-1:0]   r_addr;
    logic                w_accept;
    logic                w_word_sent;
    logic                w_pc_phase;

`ifdef REGFILE_DUMP_PC_EN
    // Set once the PC word is loaded, so the end of its last byte goes to DONE
    // and not back into the register walk.
    logic r_pc_phase;

    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_pc_phase <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_pc_phase <= 1'b0;
        end else if (r_state == ST_PC_LOAD) begin
            r_pc_phase <= 1'b1;
        end
    end

    assign w_pc_phase = r_pc_phase;
`else
    logic w_unused_pc;

    assign w_pc_phase  = 1'b0;
    assign w_unused_pc = ^pc_i;
`endif

    // A byte is consumed on an edge where valid and ready are both high.
    // Valid is high only in SEND.
    assign w_accept    = (r_state == ST_SEND) && tx_ready_i;
    assign w_word_sent = w_accept && (r_byte_cnt == c_last_byte);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next            = r_state;
        select_debug_or_wireA_o = 1'b0;
        busy_o                  = 1'b1;
        tx_valid_o              = 1'b0;
        done_o                  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                select_debug_or_wireA_o = 1'b1;
                w_state_next            = ST_SEND;
            end
            ST_SEND: begin
                select_debug_or_wireA_o = 1'b1;
                tx_valid_o              = 1'b1;
                if (w_word_sent) begin
                    if (w_pc_phase) begin
                        w_state_next = ST_DONE;
                    end else if (r_addr == c_last_addr) begin
`ifdef REGFILE_DUMP_PC_EN
                        w_state_next = ST_PC_LOAD;
`else
                        w_state_next = ST_DONE;
`endif
                    end else begin
                        w_state_next = ST_SELECT;
                    end
                end
            end
`ifdef REGFILE_DUMP_PC_EN
            ST_PC_LOAD: begin
                w_state_next = ST_SEND;
            end
`endif
            ST_DONE: begin
                done_o       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                busy_o       = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address, word shift register and byte counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            r_addr     <= '0;
            r_word     <= '0;
            r_byte_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_addr <= '0;
                    end
                end
                ST_SELECT: begin
                    // Read data is sampled only here; later changes on the
                    // port do not affect the bytes being sent.
                    r_word     <= data_ra_i;
                    r_byte_cnt <= '0;
                end
                ST_SEND: begin
                    if (w_accept) begin
                        r_word     <= r_word << NB_BYTE;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (w_word_sent && !w_pc_phase && (r_addr != c_last_addr)) begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
`ifdef REGFILE_DUMP_PC_EN
                ST_PC_LOAD: begin
                    r_word     <= pc_i;
                    r_byte_cnt <= '0;
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign addr_reg_debug_o = r_addr;
    assign tx_data_o        = r_word[NB_DATA-1 -: NB_BYTE];

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_ctrl
// Description : Self-checking bench for regfile_dump_ctrl. A register-bank
//               model drives data_ra_i. The expected byte stream comes from
//               the register contents and goes into a queue. A monitor pops
//               and compares each accepted byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_ctrl;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int N_REGS  = 32;
    localparam int NB_BYTE = 8;
    localparam int BPW     = NB_DATA / NB_BYTE;
`ifdef REGFILE_DUMP_PC_EN
    localparam int TOTAL_BYTES = (N_REGS + 1) * BPW;
    localparam int DONE_LAT    = N_REGS * (BPW + 1) + 1 + BPW + 1;
`else
    localparam int TOTAL_BYTES = N_REGS * BPW;
    localparam int DONE_LAT    = N_REGS * (BPW + 1) + 1;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [NB_DATA-1:0] data_ra;
    logic [NB_DATA-1:0] pc;
    logic               tx_ready;
    logic               sel;
    logic [NB_REG-1:0]  addr;
    logic               tx_valid;
    logic [NB_BYTE-1:0] tx_data;
    logic               busy;
    logic               done;

    regfile_dump_ctrl #(
        .NB_DATA (NB_DATA),
        .NB_REG  (NB_REG),
        .N_REGS  (N_REGS),
        .NB_BYTE (NB_BYTE)
    ) dut (
        .clock_i                 (clk),
        .reset_i                 (rst_n),
        .start_i                 (start),
        .data_ra_i               (data_ra),
        .pc_i                    (pc),
        .tx_ready_i              (tx_ready),
        .select_debug_or_wireA_o (sel),
        .addr_reg_debug_o        (addr),
        .tx_valid_o              (tx_valid),
        .tx_data_o               (tx_data),
        .busy_o                  (busy),
        .done_o                  (done)
    );

    always #5 clk = ~clk;

    // Register bank model. Port A returns the real register only while the
    // controller is in SELECT. At other times it returns random junk, so a
    // late sample of data_ra_i produces a wrong byte.
    logic [NB_DATA-1:0] regs [N_REGS];
    logic [NB_DATA-1:0] junk;
    assign data_ra = (sel && !tx_valid) ? regs[addr] : junk;

    typedef struct {
        logic [NB_BYTE-1:0] b;
        int                 a;
    } exp_t;
    exp_t q[$];

    int n_cmp  = 0;
    int n_err  = 0;
    int cyc    = 0;
    int nbytes = 0;
    int ndone  = 0;
    int done_cyc = 0;
    int ready_pct = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input drivers for transmitter readiness and bank junk.
    initial begin
        tx_ready = 1'b0;
        junk     = '0;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = (int'($urandom_range(0, 99)) < ready_pct);
            junk     = $urandom;
        end
    end

    // Monitor: byte scoreboard, select/busy rules, handshake stability.
    logic               prev_hold = 1'b0;
    logic [NB_BYTE-1:0] prev_data;
    logic [NB_REG-1:0]  prev_addr;
    always @(negedge clk) begin
        if (rst_n) begin
            if (tx_valid && tx_ready) begin
                if (q.size() == 0) begin
                    chk("extra_byte", {24'd0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("tx_data", {24'd0, tx_data}, {24'd0, e.b});
                    chk("byte_addr", {27'd0, addr}, e.a);
                end
                nbytes++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (!busy || done) chk("select_low_idle_done", {31'd0, sel}, 0);
            if (tx_valid) begin
                chk("select_high_send", {31'd0, sel}, 1);
                chk("busy_in_send", {31'd0, busy}, 1);
            end
            if (prev_hold) begin
                chk("hold_valid", {31'd0, tx_valid}, 1);
                chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
                chk("hold_addr", {27'd0, addr}, {27'd0, prev_addr});
            end
        end
        prev_hold = rst_n && tx_valid && !tx_ready;
        prev_data = tx_data;
        prev_addr = addr;
    end

    task automatic load_pattern();
        for (int k = 0; k < N_REGS; k++) regs[k] = 32'h0101_0100 * 32'(k) + 32'(k);
    endtask

    task automatic load_random();
        for (int k = 0; k < N_REGS; k++) regs[k] = $urandom;
    endtask

    // Expected stream: each register MSB first in address order, then the PC
    // word when the feature is built in. The address stays at the last one.
    task automatic push_expected();
        logic [NB_DATA-1:0] w;
        exp_t e;
        for (int k = 0; k < N_REGS; k++) begin
            w = regs[k];
            for (int b = 0; b < BPW; b++) begin
                e.b = w[NB_DATA-1-NB_BYTE*b -: NB_BYTE];
                e.a = k;
                q.push_back(e);
            end
        end
`ifdef REGFILE_DUMP_PC_EN
        w = pc;
        for (int b = 0; b < BPW; b++) begin
            e.b = w[NB_DATA-1-NB_BYTE*b -: NB_BYTE];
            e.a = N_REGS - 1;
            q.push_back(e);
        end
`endif
    endtask

    task automatic run_dump(input int pct, input bit check_lat, input int restart_at);
        int  ndone0, nbytes0, start_cyc;
        bit  timeout;
        ready_pct = pct;
        push_expected();
        ndone0  = ndone;
        nbytes0 = nbytes;
        @(posedge clk);
        #1;
        start     = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (restart_at >= 0) begin
            timeout = 1'b1;
            for (int i = 0; i < 5000; i++) begin
                if (busy && (int'(addr) == restart_at)) begin
                    timeout = 1'b0;
                    break;
                end
                @(posedge clk);
                #1;
            end
            chk("restart_point_timeout", {31'd0, timeout}, 0);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        timeout = 1'b1;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk);
            #2;
            if (ndone != ndone0) begin
                timeout = 1'b0;
                break;
            end
        end
        chk("done_timeout", {31'd0, timeout}, 0);
        repeat (3) @(posedge clk);
        #2;
        chk("done_count", ndone - ndone0, 1);
        chk("byte_count", nbytes - nbytes0, TOTAL_BYTES);
        chk("queue_empty", q.size(), 0);
        chk("busy_after", {31'd0, busy}, 0);
        if (check_lat) chk("done_latency", done_cyc - start_cyc, DONE_LAT);
        q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int ndone0, nbytes0;
        rst_n = 1'b0;
        start = 1'b0;
        pc    = 32'hDEAD_BEEF;
        load_pattern();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_valid", {31'd0, tx_valid}, 0);
        chk("rst_select", {31'd0, sel}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_addr", {27'd0, addr}, 0);
        chk("rst_tx_data", {24'd0, tx_data}, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pattern registers, transmitter always ready, latency checked.
        run_dump(100, 1'b1, -1);

        // Random registers and PC, 30% ready duty.
        load_random();
        pc = $urandom;
        run_dump(30, 1'b0, -1);

        // Extra start pulse mid-dump at register 10 must be ignored.
        load_random();
        run_dump(60, 1'b0, 10);

        // Reset during register 5, byte 2.
        load_pattern();
        pc        = 32'hDEAD_BEEF;
        ready_pct = 100;
        push_expected();
        ndone0  = ndone;
        nbytes0 = nbytes;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (nbytes - nbytes0 == 5 * BPW + 2) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("reset_point_timeout", {31'd0, found}, 1);
        chk("reset_point_addr", {27'd0, addr}, 5);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        chk("midrst_tx_valid", {31'd0, tx_valid}, 0);
        chk("midrst_select", {31'd0, sel}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_addr", {27'd0, addr}, 0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("midrst_no_done", ndone - ndone0, 0);
        chk("midrst_idle", {31'd0, busy}, 0);

        // A fresh start after the reset restarts from register 0.
        run_dump(100, 1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
